// File: rtl/dilithium_host_seq.sv
// Host-side sequencer for the Dilithium adapter stream interface: streams operands
// from a source RAM through a 2-entry prefetch FIFO and collects results into a sink RAM.
module dilithium_host_seq #(
  parameter int SEED_WORDS = 8,
  parameter int PK_WORDS   = 328,
  parameter int SK_WORDS   = 632,
  parameter int SIG_WORDS  = 605,
  parameter int AW         = 12,
  parameter int TIMEOUT    = 2**20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_mode,
  input  logic [31:0]   cmd_msg_len,
  output logic          src_rd_en,
  output logic [AW-1:0] src_addr,
  input  logic [31:0]   src_rd_data,
  output logic          snk_wr_en,
  output logic [AW-1:0] snk_addr,
  output logic [31:0]   snk_wr_data,
  output logic          start,
  output logic [1:0]    mode,
  output logic          valid_i,
  input  logic          ready_i,
  output logic [31:0]   data_i,
  input  logic          valid_o,
  output logic          ready_o,
  input  logic [31:0]   data_o,
  input  logic          done,
  output logic          busy,
  output logic          cmp_valid,
  output logic          verify_ok,
  output logic          err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] MODE_VERIFY = 2'd1;
  localparam logic [1:0] MODE_SIGN   = 2'd2;
  localparam logic [1:0] MODE_BAD    = 2'd3;

  typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, FINISH} state_t;
  state_t state, state_nxt;

  logic [1:0]    mode_r;
  logic [31:0]   len_r;
  logic [31:0]   iss_cnt, sent_cnt, out_cnt;
  logic          inflight, inflight_len;
  logic [31:0]   fifo_mem [2];
  logic          fifo_wp, fifo_rp;
  logic [1:0]    fifo_cnt;
  logic          done_seen;
  logic [TW-1:0] idle_cnt;

  logic [31:0] msg_words, in_total, len_pos, out_total;
  logic        has_len;
  logic        accept, bad_cmd, in_hs, out_hs, issue, issue_len, out_last, timeout_hit;

  // Command-dependent stream geometry: LEN word slot, total input words, expected outputs
  always_comb begin
    msg_words = 32'((33'(len_r) + 33'd3) >> 2);
    if (msg_words == 32'd0) msg_words = 32'd1;
    has_len   = 1'b0;
    len_pos   = 32'd0;
    in_total  = 32'(SEED_WORDS);
    out_total = 32'(SK_WORDS + PK_WORDS);
    case (mode_r)
      MODE_VERIFY: begin
        has_len   = 1'b1;
        len_pos   = 32'(PK_WORDS + SIG_WORDS);
        in_total  = 32'(PK_WORDS + SIG_WORDS + 1) + msg_words;
        out_total = 32'd1;
      end
      MODE_SIGN: begin
        has_len   = 1'b1;
        len_pos   = 32'(SK_WORDS);
        in_total  = 32'(SK_WORDS + 1) + msg_words;
        out_total = 32'(SIG_WORDS);
      end
      default: ;
    endcase
  end

  assign accept  = (state == IDLE) && cmd_valid && (cmd_mode != MODE_BAD);
  assign bad_cmd = (state == IDLE) && cmd_valid && (cmd_mode == MODE_BAD);
  assign in_hs   = valid_i && ready_i;
  assign out_hs  = valid_o && ready_o;

  // A word popped this cycle frees a slot, which keeps one issue per cycle sustainable
  assign issue     = (state == STREAM) && (iss_cnt < in_total) &&
                     (({1'b0, fifo_cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, in_hs}));
  assign issue_len = issue && has_len && (iss_cnt == len_pos);
  assign src_rd_en = issue && !issue_len;

  assign cmd_ready   = (state == IDLE) && !rst;
  assign start       = (state == START);
  assign busy        = (state != IDLE);
  assign cmp_valid   = (state == FINISH);
  assign mode        = (state != IDLE) ? mode_r : 2'd0;
  assign valid_i     = (state == STREAM) && (fifo_cnt != 2'd0);
  assign data_i      = valid_i ? fifo_mem[fifo_rp] : 32'd0;
  assign ready_o     = (state != IDLE);
  assign snk_wr_en   = out_hs && (out_cnt < out_total);
  assign snk_addr    = snk_wr_en ? out_cnt[AW-1:0] : '0;
  assign snk_wr_data = snk_wr_en ? data_o : 32'd0;

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    out_last    = (out_cnt == out_total) || (snk_wr_en && (out_cnt + 32'd1 == out_total));
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   state_nxt = STREAM;
      STREAM:  if (in_hs && (sent_cnt + 32'd1 == in_total)) state_nxt = DRAIN;
      DRAIN:   if (out_last && (done_seen || done)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if ((state inside {START, STREAM, DRAIN}) && !(in_hs || out_hs) &&
        (idle_cnt == TW'(TIMEOUT - 1))) begin
      timeout_hit = 1'b1;
      state_nxt   = FINISH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mode_r       <= 2'd0;
      len_r        <= 32'd0;
      iss_cnt      <= 32'd0;
      sent_cnt     <= 32'd0;
      out_cnt      <= 32'd0;
      src_addr     <= '0;
      inflight     <= 1'b0;
      inflight_len <= 1'b0;
      fifo_mem[0]  <= 32'd0;
      fifo_mem[1]  <= 32'd0;
      fifo_wp      <= 1'b0;
      fifo_rp      <= 1'b0;
      fifo_cnt     <= 2'd0;
      done_seen    <= 1'b0;
      idle_cnt     <= '0;
      err          <= 1'b0;
      verify_ok    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mode_r       <= cmd_mode;
        len_r        <= cmd_msg_len;
        iss_cnt      <= 32'd0;
        sent_cnt     <= 32'd0;
        out_cnt      <= 32'd0;
        src_addr     <= '0;
        inflight     <= 1'b0;
        inflight_len <= 1'b0;
        fifo_wp      <= 1'b0;
        fifo_rp      <= 1'b0;
        fifo_cnt     <= 2'd0;
        done_seen    <= 1'b0;
        idle_cnt     <= '0;
        err          <= 1'b0;
        verify_ok    <= 1'b0;
      end else begin
        if (bad_cmd || timeout_hit) err <= 1'b1;
        if (issue) iss_cnt <= iss_cnt + 32'd1;
        if (src_rd_en) src_addr <= src_addr + 1'b1;
        inflight     <= issue;
        inflight_len <= issue_len;
        // RAM data (or the internal LEN word) lands one cycle after its issue
        if (inflight) begin
          fifo_mem[fifo_wp] <= inflight_len ? len_r : src_rd_data;
          fifo_wp           <= ~fifo_wp;
        end
        if (in_hs) begin
          fifo_rp  <= ~fifo_rp;
          sent_cnt <= sent_cnt + 32'd1;
        end
        fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, in_hs};
        if (snk_wr_en) begin
          out_cnt <= out_cnt + 32'd1;
          if (mode_r == MODE_VERIFY) verify_ok <= data_o[0];
        end
        if (done && (state != IDLE)) done_seen <= 1'b1;
        if (state != IDLE) idle_cnt <= (in_hs || out_hs) ? '0 : idle_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dilithium_host_seq.sv
// Self-checking bench for dilithium_host_seq: a behavioural adapter/RAM model drives
// randomized handshakes and every command is compared against a queue-based reference.
module tb_dilithium_host_seq;
  localparam int SEED_WORDS = 8;
  localparam int PK_WORDS   = 328;
  localparam int SK_WORDS   = 632;
  localparam int SIG_WORDS  = 605;
  localparam int AW         = 12;
  localparam int TIMEOUT    = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [1:0]    cmd_mode = 2'd0;
  logic [31:0]   cmd_msg_len = 32'd0;
  logic          src_rd_en;
  logic [AW-1:0] src_addr;
  logic [31:0]   src_rd_data = 32'd0;
  logic          snk_wr_en;
  logic [AW-1:0] snk_addr;
  logic [31:0]   snk_wr_data;
  logic          start;
  logic [1:0]    mode;
  logic          valid_i;
  logic          ready_i = 1'b0;
  logic [31:0]   data_i;
  logic          valid_o = 1'b0;
  logic          ready_o;
  logic [31:0]   data_o = 32'd0;
  logic          done = 1'b0;
  logic          busy, cmp_valid, verify_ok, err;

  dilithium_host_seq #(
    .SEED_WORDS(SEED_WORDS), .PK_WORDS(PK_WORDS), .SK_WORDS(SK_WORDS),
    .SIG_WORDS(SIG_WORDS), .AW(AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_msg_len(cmd_msg_len), .src_rd_en(src_rd_en),
    .src_addr(src_addr), .src_rd_data(src_rd_data), .snk_wr_en(snk_wr_en),
    .snk_addr(snk_addr), .snk_wr_data(snk_wr_data), .start(start), .mode(mode),
    .valid_i(valid_i), .ready_i(ready_i), .data_i(data_i), .valid_o(valid_o),
    .ready_o(ready_o), .data_o(data_o), .done(done), .busy(busy),
    .cmp_valid(cmp_valid), .verify_ok(verify_ok), .err(err)
  );

  always #5 clk = ~clk;

  logic [31:0] src_mem [4096];
  always @(posedge clk) if (src_rd_en) src_rd_data <= src_mem[src_addr];

  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] in_q[$], exp_in[$], out_data[$];
  logic [31:0] sink_mem [4096];
  int wr_cnt, wr_addr_viol, start_cnt, cmp_cnt, stall_viol, rd_viol, rd_cnt, mode_viol;
  int cyc, start_cyc, cmp_cyc;
  bit finished, ready_at_issue;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference input stream: RAM words in order with the LEN word spliced in
  function automatic void buildInputs(input logic [1:0] m, input logic [31:0] len);
    int pre, mw;
    exp_in.delete();
    mw  = (len == 0) ? 1 : int'((longint'(len) + 3) / 4);
    pre = (m == 2'd0) ? SEED_WORDS : (m == 2'd1) ? PK_WORDS + SIG_WORDS : SK_WORDS;
    for (int i = 0; i < pre; i++) exp_in.push_back(src_mem[i]);
    if (m != 2'd0) begin
      exp_in.push_back(len);
      for (int i = 0; i < mw; i++) exp_in.push_back(src_mem[pre + i]);
    end
  endfunction

  function automatic int expOutputs(input logic [1:0] m);
    return (m == 2'd0) ? SK_WORDS + PK_WORDS : (m == 2'd1) ? 1 : SIG_WORDS;
  endfunction

  task automatic applyStimulus(input logic [1:0] m, input logic [31:0] len, input int ready_pct,
                               input int extra, input bit done_with_last, input bit vbit,
                               input int budget);
    int n_in, n_out, out_ptr;
    bit out_hs, prev_stall;
    logic [31:0] prev_data, w;
    in_q.delete();
    out_data.delete();
    for (int i = 0; i < 4096; i++) sink_mem[i] = 32'hDEADBEEF;
    wr_cnt = 0; wr_addr_viol = 0; start_cnt = 0; cmp_cnt = 0; stall_viol = 0;
    rd_viol = 0; rd_cnt = 0; mode_viol = 0; start_cyc = -1; cmp_cyc = -1;
    finished = 0; ready_at_issue = 0;
    buildInputs(m, len);
    n_in  = exp_in.size();
    n_out = expOutputs(m);
    for (int i = 0; i < n_out + extra; i++) begin
      w = $urandom();
      out_data.push_back((m == 2'd1) ? 32'(vbit) : w);
    end
    out_ptr = 0; out_hs = 0; prev_stall = 0; prev_data = 32'd0; cyc = 0;
    while (!finished && cyc < budget) begin
      @(negedge clk);
      if (out_hs) out_ptr++;
      cmd_valid   = (cyc == 0);
      cmd_mode    = m;
      cmd_msg_len = len;
      ready_i     = ($urandom_range(99) < ready_pct);
      valid_o     = (in_q.size() >= n_in) && (out_ptr < out_data.size());
      data_o      = valid_o ? out_data[out_ptr] : 32'd0;
      if (in_q.size() >= n_in &&
          (done_with_last ? (out_ptr + 1 >= out_data.size()) : (out_ptr >= out_data.size())))
        done = 1'b1;
      #1;
      if (cyc == 0) ready_at_issue = cmd_ready;
      if (valid_i && ready_i) in_q.push_back(data_i);
      if (prev_stall && (!valid_i || data_i !== prev_data)) stall_viol++;
      prev_stall = valid_i && !ready_i;
      prev_data  = data_i;
      out_hs = valid_o && ready_o;
      if (snk_wr_en) begin
        if (snk_addr != AW'(wr_cnt)) wr_addr_viol++;
        sink_mem[snk_addr] = snk_wr_data;
        wr_cnt++;
      end
      if (src_rd_en) begin
        if (src_addr != AW'(rd_cnt)) rd_viol++;
        rd_cnt++;
      end
      if (busy && mode !== m) mode_viol++;
      if (start) begin start_cnt++; start_cyc = cyc; end
      if (cmp_valid) begin cmp_cnt++; cmp_cyc = cyc; finished = 1; end
      cyc++;
    end
    cmd_valid = 0; ready_i = 0; valid_o = 0; data_o = 0; done = 0;
  endtask

  task automatic checkCommand(input string tag, input logic [1:0] m, input bit exp_err,
                              input bit exp_vok);
    int mism;
    checkOutput({tag, ".finished"}, 64'(finished), 1);
    checkOutput({tag, ".cmd_ready"}, 64'(ready_at_issue), 1);
    checkOutput({tag, ".start_cnt"}, start_cnt, 1);
    checkOutput({tag, ".cmp_cnt"}, cmp_cnt, 1);
    checkOutput({tag, ".in_cnt"}, in_q.size(), exp_in.size());
    mism = 0;
    for (int i = 0; i < in_q.size() && i < exp_in.size(); i++) if (in_q[i] !== exp_in[i]) mism++;
    checkOutput({tag, ".in_data"}, mism, 0);
    checkOutput({tag, ".src_reads"}, rd_cnt, exp_in.size() - ((m == 2'd0) ? 0 : 1));
    checkOutput({tag, ".src_addr_order"}, rd_viol, 0);
    checkOutput({tag, ".stall_stable"}, stall_viol, 0);
    checkOutput({tag, ".mode_held"}, mode_viol, 0);
    checkOutput({tag, ".sink_writes"}, wr_cnt, expOutputs(m));
    checkOutput({tag, ".sink_addr_order"}, wr_addr_viol, 0);
    mism = 0;
    for (int i = 0; i < expOutputs(m); i++) if (sink_mem[i] !== out_data[i]) mism++;
    checkOutput({tag, ".sink_data"}, mism, 0);
    @(negedge clk); #1;
    checkOutput({tag, ".err"}, 64'(err), 64'(exp_err));
    checkOutput({tag, ".verify_ok"}, 64'(verify_ok), 64'(exp_vok));
    checkOutput({tag, ".idle_busy"}, 64'(busy), 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) src_mem[i] = $urandom();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset.ctrl", {cmd_ready, src_rd_en, snk_wr_en, start, mode, valid_i,
                               ready_o, busy, cmp_valid, verify_ok, err}, 0);
    checkOutput("reset.addr", {src_addr, snk_addr}, 0);
    checkOutput("reset.data", {data_i, snk_wr_data}, 0);
    rst = 1'b0;
    @(negedge clk); #1;
    checkOutput("idle.cmd_ready", 64'(cmd_ready), 1);

    applyStimulus(2'd0, 32'd0, 50, 0, 0, 0, 5000);
    checkCommand("keygen", 2'd0, 0, 0);
    applyStimulus(2'd2, 32'd5, 50, 2, 0, 0, 8000);
    checkCommand("sign_len5_extra", 2'd2, 0, 0);
    applyStimulus(2'd2, 32'd0, 100, 0, 1, 0, 8000);
    checkCommand("sign_len0", 2'd2, 0, 0);
    applyStimulus(2'd1, 32'd13, 50, 0, 1, 1, 8000);
    checkCommand("verify_ok1", 2'd1, 0, 1);
    applyStimulus(2'd1, 32'd4, 100, 0, 0, 0, 8000);
    checkCommand("verify_ok0", 2'd1, 0, 0);

    // Rejected mode: err raised, no start pulse, stays idle
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = 2'd3; cmd_msg_len = 32'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    start_cnt = 0; mode_viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (start) start_cnt++;
      if (busy) mode_viol++;
    end
    checkOutput("badmode.err", 64'(err), 1);
    checkOutput("badmode.start", start_cnt, 0);
    checkOutput("badmode.busy", mode_viol, 0);

    // Input side never ready: timeout after TIMEOUT silent cycles
    applyStimulus(2'd0, 32'd0, 0, 0, 0, 0, 500);
    checkOutput("timeout.finished", 64'(finished), 1);
    checkOutput("timeout.cmp_cnt", cmp_cnt, 1);
    checkOutput("timeout.latency", 64'(cmp_cyc - start_cyc), TIMEOUT);
    checkOutput("timeout.in_cnt", in_q.size(), 0);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("timeout.err_sticky", 64'(err), 1);
    checkOutput("timeout.idle", 64'(busy), 0);
    applyStimulus(2'd2, 32'd3, 50, 0, 0, 0, 8000);
    checkCommand("sign_after_timeout", 2'd2, 0, 0);

    // Asynchronous reset in the middle of streaming
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_msg_len = 32'd0; ready_i = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("midrst.streaming", {busy, valid_i}, 2'b11);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst.ctrl", {cmd_ready, src_rd_en, snk_wr_en, start, mode, valid_i,
                                ready_o, busy, cmp_valid, verify_ok, err}, 0);
    checkOutput("midrst.addr", {src_addr, snk_addr}, 0);
    checkOutput("midrst.data", {data_i, snk_wr_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(2'd0, 32'd0, 50, 0, 0, 0, 5000);
    checkCommand("keygen_after_rst", 2'd0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
